// File: rtl/iob_regfile_nw_wr.sv
// iob_regfile_nw_wr: narrow-write/wide-read register file with per-slice valid flags and full-word count.
module iob_regfile_nw_wr #(
  parameter int WDATA_W = 8,
  parameter int RDATA_W = 32,
  parameter int RADDR_W = 2,
  parameter int RCLR = 1,
  localparam int R = RDATA_W / WDATA_W,
  localparam int WADDR_W = RADDR_W + $clog2(R)
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               cke_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [WADDR_W-1:0] waddr_i,
  input  logic [WDATA_W-1:0] wdata_i,
  input  logic               rreq_i,
  input  logic [RADDR_W-1:0] raddr_i,
  output logic [RDATA_W-1:0] rdata_o,
  output logic               rvalid_o,
  output logic               rfull_o,
  output logic [RADDR_W:0]   nfull_o
);
  localparam int DEPTH = 2 ** RADDR_W;
  localparam int SW = (R > 1) ? $clog2(R) : 1;
  logic [RDATA_W-1:0] mem [DEPTH];
  logic [R-1:0] vld [DEPTH];
  logic [R-1:0] vld_n [DEPTH];
  logic [RADDR_W-1:0] wword;
  logic [SW-1:0] wsl;
  logic [RADDR_W:0] cnt;
  assign wword = waddr_i[WADDR_W-1 -: RADDR_W];
  assign wsl = SW'(waddr_i % WADDR_W'(R));
  // clear is applied before the write so a same-word write keeps its own flag
  always_comb begin
    vld_n = vld;
    if (rreq_i && RCLR != 0) vld_n[raddr_i] = '0;
    if (we_i) vld_n[wword][wsl] = 1'b1;
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) cnt = cnt + (RADDR_W+1)'(&vld_n[k]);
  end
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
        vld[k] <= '0;
      end
      rdata_o <= '0;
      rvalid_o <= 1'b0;
      rfull_o <= 1'b0;
      nfull_o <= '0;
    end else if (cke_i) begin
      if (rst_i) begin
        for (int k = 0; k < DEPTH; k++) begin
          mem[k] <= '0;
          vld[k] <= '0;
        end
        rdata_o <= '0;
        rvalid_o <= 1'b0;
        rfull_o <= 1'b0;
        nfull_o <= '0;
      end else begin
        if (we_i) mem[wword][wsl*WDATA_W +: WDATA_W] <= wdata_i;
        vld <= vld_n;
        nfull_o <= cnt;
        rvalid_o <= rreq_i;
        if (rreq_i) begin
          rdata_o <= mem[raddr_i];
          rfull_o <= &vld[raddr_i];
        end
      end
    end
  end
endmodule

// File: tb/tb_iob_regfile_nw_wr.sv
// tb_iob_regfile_nw_wr: scoreboard bench with a slice-level reference model and randomized traffic.
module tb_iob_regfile_nw_wr;
  localparam int D = 4;
  localparam int R = 4;
  logic clk = 0, arst = 1, cke = 0, rst = 0, we = 0, rreq = 0;
  logic [3:0] waddr = 0;
  logic [7:0] wdata = 0;
  logic [1:0] raddr = 0;
  logic [31:0] rdata;
  logic rvalid, rfull;
  logic [2:0] nfull;
  iob_regfile_nw_wr #(.WDATA_W(8), .RDATA_W(32), .RADDR_W(2), .RCLR(1)) dut (
    .clk_i(clk), .arst_i(arst), .cke_i(cke), .rst_i(rst), .we_i(we), .waddr_i(waddr),
    .wdata_i(wdata), .rreq_i(rreq), .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid),
    .rfull_o(rfull), .nfull_o(nfull)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] d; logic f;} exp_t;
  exp_t q[$];
  byte unsigned m_data [D][R];
  bit m_vld [D][R];
  bit l_valid;
  logic [31:0] l_data;
  bit l_full;
  int checks = 0, failures = 0;
  bit mon_en = 0;
  function automatic logic [31:0] word_of(int k);
    logic [31:0] w = 0;
    for (int s = 0; s < R; s++) w = w | (32'(m_data[k][s]) << (8 * s));
    return w;
  endfunction
  function automatic bit full_of(int k);
    int n = 0;
    for (int s = 0; s < R; s++) n += m_vld[k][s];
    return n == R;
  endfunction
  function automatic logic [2:0] nfull_model();
    int n = 0;
    for (int k = 0; k < D; k++) n += full_of(k);
    return 3'(n);
  endfunction
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic clear_model();
    for (int k = 0; k < D; k++)
      for (int s = 0; s < R; s++) begin
        m_data[k][s] = 0;
        m_vld[k][s] = 0;
      end
    l_valid = 0; l_data = 0; l_full = 0;
    q.delete();
  endtask
  task automatic step(logic c, logic r, logic w, logic [3:0] wa, logic [7:0] wd, logic rq, logic [1:0] ra);
    @(negedge clk);
    cke = c; rst = r; we = w; waddr = wa; wdata = wd; rreq = rq; raddr = ra;
    if (!c) begin
      if (l_valid) q.push_back('{l_data, l_full});
    end else if (r) begin
      clear_model();
    end else begin
      if (rq) begin
        l_valid = 1; l_data = word_of(int'(ra)); l_full = full_of(int'(ra));
        q.push_back('{l_data, l_full});
        for (int s = 0; s < R; s++) m_vld[ra][s] = 0;
      end else l_valid = 0;
      if (w) begin
        m_data[wa / R][wa % R] = wd;
        m_vld[wa / R][wa % R] = 1;
      end
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("rvalid", 64'(rvalid), 64'd1);
        if (rvalid) begin
          check("rdata", 64'(rdata), 64'(e.d));
          check("rfull", 64'(rfull), 64'(e.f));
        end
      end else check("rvalid_idle", 64'(rvalid), 64'd0);
      check("nfull", 64'(nfull), 64'(nfull_model()));
    end
  end
  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", 64'(rdata), 0);
    check("rst_rvalid", 64'(rvalid), 0);
    check("rst_nfull", 64'(nfull), 0);
    @(negedge clk);
    arst = 0;
    mon_en = 1;
    for (int i = 0; i < 4; i++) step(1, 0, 1, 4'(4 + i), 8'(8'h11 * (i + 1)), 0, 0);
    step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 1, 4'd9, 8'hAB, 0, 0);
    step(1, 0, 0, 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 4'(i), 8'(8'hA0 + i), 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 4'(12 + i), 8'(8'hC0 + i), 0, 0);
    step(1, 0, 1, 4'd15, 8'hCF, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 4'(4 + i), 8'(8'h61 + i), 0, 0);
    step(1, 0, 1, 4'd5, 8'h55, 1, 1);
    step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 4'd8, 8'h77, 0, 0);
    for (int i = 0; i < 3; i++) step(0, i == 1, 1, 4'(i), 8'hEE, 1, 2'(i));
    step(1, 0, 0, 0, 0, 1, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 4'(i), 8'hDD, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 4'd0, 8'h5A, 1, 1);
    @(negedge clk);
    cke = 1; rst = 1; we = 1; waddr = 1; rreq = 1; raddr = 0;
    clear_model();
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 1, 4'd2, 8'h3C, 1, 3);
    @(negedge clk);
    cke = 1; rst = 0; we = 0; rreq = 1; raddr = 3;
    #1 arst = 1;
    #1;
    check("arst_rvalid", 64'(rvalid), 0);
    check("arst_rdata", 64'(rdata), 0);
    check("arst_nfull", 64'(nfull), 0);
    arst = 0; rreq = 0;
    clear_model();
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0,
           2'($urandom_range(0, 3)));
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
